// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the DLX fetch stage.
// Decides when the PC and the pipeline registers advance (run / single-step / halt, hazard
// stalls), selects the next PC (branch > jump > sequential) and counts advancing cycles.
// Ports:
//   i_clock, i_reset                 clock, synchronous active-low reset
//   i_run, i_step, i_halt_req        debug-unit command pulses
//   i_halt_instr                     HALT opcode seen in ID
//   i_stall                          load-use stall from the hazard unit
//   i_branch_taken/i_branch_addr     taken branch and its target
//   i_jump/i_jump_addr               jump and its target
//   i_pc                             current PC
//   o_mux_pc                         next PC for the program counter
//   o_pc_enable, o_pipe_enable       PC / pipeline-register enable
//   o_flush                          flush IF/ID on a redirect
//   o_state, o_halted, o_step_done   sequencer status
//   o_cycle_count                    saturating count of advancing cycles
module pc_sequencer #(
  parameter int unsigned NB      = 32,
  parameter int unsigned PC_INCR = 4,
  parameter int unsigned NB_CNT  = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_halt_instr,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [NB-1:0]     i_branch_addr,
  input  logic              i_jump,
  input  logic [NB-1:0]     i_jump_addr,
  input  logic [NB-1:0]     i_pc,
  output logic [NB-1:0]     o_mux_pc,
  output logic              o_pc_enable,
  output logic              o_pipe_enable,
  output logic              o_flush,
  output logic [1:0]        o_state,
  output logic              o_halted,
  output logic              o_step_done,
  output logic [NB_CNT-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StHalted = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                step_done_q, step_done_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                halt_any;
  logic                active;
  logic                pc_enable;

  assign halt_any = i_halt_instr | i_halt_req;
  assign active   = (state_q == StRun) || (state_q == StStep);
  // A HALT instruction must not advance: the PC stays parked on the HALT address.
  assign pc_enable = active & ~i_stall & ~halt_any;

  always_comb begin
    if (i_branch_taken) begin
      o_mux_pc = i_branch_addr;
    end else if (i_jump) begin
      o_mux_pc = i_jump_addr;
    end else begin
      o_mux_pc = i_pc + NB'(PC_INCR);
    end
  end

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_run) begin
          state_d = StRun;
        end else if (i_step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (halt_any) state_d = StHalted;
      end
      StStep: begin
        // Halt beats completion, so a halted step never reports done.
        if (halt_any) begin
          state_d = StHalted;
        end else if (!i_stall) begin
          state_d     = StIdle;
          step_done_d = 1'b1;
        end
      end
      StHalted: state_d = StHalted;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_enable && (cnt_q != {NB_CNT{1'b1}})) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      step_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_pc_enable   = pc_enable;
  assign o_pipe_enable = pc_enable;
  // A stall suppresses the flush as well; upstream re-presents the redirect.
  assign o_flush       = pc_enable & (i_branch_taken | i_jump);
  assign o_state       = state_q;
  assign o_halted      = (state_q == StHalted);
  assign o_step_done   = step_done_q;
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;

  logic        clk = 1'b1;
  logic        rst, run, step, halt_req, halt_instr, stall, br, jmp;
  logic [31:0] br_addr, jmp_addr, pc;
  logic [31:0] mux_pc, mux_pc_s;
  logic        pc_en, pipe_en, flush, halted, step_done;
  logic        pc_en_s, pipe_en_s, flush_s, halted_s, step_done_s;
  logic [1:0]  state, state_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_halt_req(halt_req),
    .i_halt_instr(halt_instr), .i_stall(stall), .i_branch_taken(br), .i_branch_addr(br_addr),
    .i_jump(jmp), .i_jump_addr(jmp_addr), .i_pc(pc), .o_mux_pc(mux_pc), .o_pc_enable(pc_en),
    .o_pipe_enable(pipe_en), .o_flush(flush), .o_state(state), .o_halted(halted),
    .o_step_done(step_done), .o_cycle_count(cnt)
  );

  pc_sequencer #(.NB_CNT(4)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_halt_req(halt_req),
    .i_halt_instr(halt_instr), .i_stall(stall), .i_branch_taken(br), .i_branch_addr(br_addr),
    .i_jump(jmp), .i_jump_addr(jmp_addr), .i_pc(pc), .o_mux_pc(mux_pc_s),
    .o_pc_enable(pc_en_s), .o_pipe_enable(pipe_en_s), .o_flush(flush_s), .o_state(state_s),
    .o_halted(halted_s), .o_step_done(step_done_s), .o_cycle_count(cnt_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, step-done flag and counters, advanced once per clock.
  int     mode = M_IDLE;
  bit     done_m = 1'b0;
  bit     valid = 1'b0;
  longint cnt_m = 0, cnt4_m = 0;

  initial forever begin
    logic        en_e;
    logic [31:0] mux_e;
    @(negedge clk);
    #3;
    en_e = (mode == M_RUN || mode == M_STEP) && !stall && !halt_instr && !halt_req;
    if (br)       mux_e = br_addr;
    else if (jmp) mux_e = jmp_addr;
    else          mux_e = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
    if (valid) begin
      chk("state", 64'(state), 64'(mode));
      chk("pc_enable", 64'(pc_en), 64'(en_e));
      chk("pipe_enable", 64'(pipe_en), 64'(en_e));
      chk("flush", 64'(flush), 64'(en_e && (br || jmp)));
      chk("halted", 64'(halted), 64'(mode == M_HALTED));
      chk("step_done", 64'(step_done), 64'(done_m));
      chk("mux_pc", 64'(mux_pc), 64'(mux_e));
      chk("cycle_count", 64'(cnt), 64'(cnt_m));
      chk("cycle_count_sat", 64'(cnt_s), 64'(cnt4_m));
    end
    if (!rst) begin
      mode = M_IDLE; done_m = 1'b0; cnt_m = 0; cnt4_m = 0; valid = 1'b1;
    end else begin
      done_m = 1'b0;
      if (en_e) begin
        if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
        if (cnt4_m < 15) cnt4_m++;
      end
      case (mode)
        M_IDLE:   if (run) mode = M_RUN; else if (step) mode = M_STEP;
        M_RUN:    if (halt_req || halt_instr) mode = M_HALTED;
        M_STEP: begin
          if (halt_req || halt_instr) mode = M_HALTED;
          else if (!stall) begin mode = M_IDLE; done_m = 1'b1; end
        end
        default:  mode = M_HALTED;
      endcase
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; run = 0; step = 0; halt_req = 0; halt_instr = 0; stall = 0; br = 0; jmp = 0;
    br_addr = '0; jmp_addr = '0; pc = '0;
    nxt(); nxt();
    // Reset released, run pulse.
    rst = 1'b1; run = 1'b1; pc = 32'h0;
    #3 chk("lit_reset_state", 64'(state), 64'd0); chk("lit_reset_cnt", 64'(cnt), 64'd0);
    chk("lit_reset_en", 64'(pc_en), 64'd0);
    nxt(); run = 1'b0;
    #3 chk("lit_run_state", 64'(state), 64'd1); chk("lit_run_en", 64'(pc_en), 64'd1);
    chk("lit_run_mux", 64'(mux_pc), 64'd4);
    nxt(); pc = 32'h4;
    #3 chk("lit_cnt1", 64'(cnt), 64'd1); chk("lit_mux8", 64'(mux_pc), 64'd8);
    nxt(); pc = 32'h8;
    #3 chk("lit_cnt2", 64'(cnt), 64'd2);
    nxt(); pc = 32'hC;
    #3 chk("lit_cnt3", 64'(cnt), 64'd3);
    // Redirect priority, then the same redirect under a stall.
    nxt(); br = 1'b1; br_addr = 32'h40; jmp = 1'b1; jmp_addr = 32'h80;
    #3 chk("lit_redir_mux", 64'(mux_pc), 64'h40); chk("lit_redir_flush", 64'(flush), 64'd1);
    nxt(); stall = 1'b1;
    #3 chk("lit_stall_en", 64'(pc_en), 64'd0); chk("lit_stall_flush", 64'(flush), 64'd0);
    nxt(); stall = 1'b0; br = 1'b0;
    #3 chk("lit_jump_mux", 64'(mux_pc), 64'h80);
    nxt(); jmp = 1'b0; pc = 32'hFFFF_FFFC;
    #3 chk("lit_wrap_mux", 64'(mux_pc), 64'd0);
    for (int i = 0; i < 14; i++) begin
      nxt(); pc = 32'(i * 4);
    end
    // HALT instruction: 21 advancing cycles so far.
    nxt(); pc = 32'h20; halt_instr = 1'b1;
    #3 chk("lit_halt_en", 64'(pc_en), 64'd0); chk("lit_sat_cnt", 64'(cnt_s), 64'hF);
    chk("lit_cnt21", 64'(cnt), 64'd21); chk("lit_halt_mux", 64'(mux_pc), 64'h24);
    nxt(); halt_instr = 1'b0; run = 1'b1;
    #3 chk("lit_halted_state", 64'(state), 64'd3); chk("lit_halted", 64'(halted), 64'd1);
    nxt(); run = 1'b0; step = 1'b1;
    nxt(); step = 1'b0;
    #3 chk("lit_sticky", 64'(state), 64'd3);
    nxt(); rst = 1'b0;
    // Single step from IDLE.
    nxt(); rst = 1'b1; step = 1'b1; pc = 32'h8;
    #3 chk("lit_rst_state", 64'(state), 64'd0); chk("lit_rst_cnt", 64'(cnt), 64'd0);
    nxt(); step = 1'b0;
    #3 chk("lit_step_state", 64'(state), 64'd2); chk("lit_step_mux", 64'(mux_pc), 64'd12);
    chk("lit_step_en", 64'(pc_en), 64'd1);
    nxt(); pc = 32'hC;
    #3 chk("lit_step_done", 64'(step_done), 64'd1); chk("lit_step_idle", 64'(state), 64'd0);
    nxt();
    #3 chk("lit_step_done_off", 64'(step_done), 64'd0);
    // Step held by a 3-cycle stall.
    nxt(); step = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nxt(); step = 1'b0; stall = 1'b1;
      #3 chk("lit_sstall_en", 64'(pc_en), 64'd0); chk("lit_sstall_state", 64'(state), 64'd2);
    end
    nxt(); stall = 1'b0;
    #3 chk("lit_sstall_go", 64'(pc_en), 64'd1);
    nxt();
    #3 chk("lit_sstall_done", 64'(step_done), 64'd1);
    // Halt request during a step: no done pulse.
    nxt(); step = 1'b1;
    nxt(); step = 1'b0; halt_req = 1'b1;
    nxt(); halt_req = 1'b0;
    #3 chk("lit_shalt_state", 64'(state), 64'd3); chk("lit_shalt_done", 64'(step_done), 64'd0);
    nxt(); rst = 1'b0;
    // Run and step together: run wins.
    nxt(); rst = 1'b1; run = 1'b1; step = 1'b1;
    nxt(); run = 1'b0; step = 1'b0;
    #3 chk("lit_run_wins", 64'(state), 64'd1);
    nxt(); nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
